// File: rtl/ili9341_pkg.sv
// Shared constants, FSM encoding and helpers for the ILI9341 serial receiver.
package ili9341_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  localparam logic [15:0] COLOR_RED  = 16'hF800;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CASET0,
    ST_CASET1,
    ST_CASET2,
    ST_CASET3,
    ST_PASET0,
    ST_PASET1,
    ST_PASET2,
    ST_PASET3,
    ST_RAMWR_HI,
    ST_RAMWR_LO,
    ST_SKIP
  } rx_state_e;

  // Window end values beyond the panel are pulled back to the last row/column.
  function automatic logic [15:0] clamp_end(input logic [15:0] e, input logic [15:0] lim);
    return (e > lim) ? lim : e;
  endfunction

endpackage

// File: rtl/ili9341_spi_rx_if.sv
// Four-wire LCD serial link: the controller drives it, the receiver observes it.
interface ili9341_spi_rx_if;
  logic cs_n;
  logic sck;
  logic mosi;
  logic dc;

  modport master (output cs_n, output sck, output mosi, output dc);
  modport slave  (input  cs_n, input  sck, input  mosi, input  dc);
endinterface

// File: rtl/ili9341_spi_rx_byte.sv
// Synchronizes the serial link into clk, detects sck rising edges and
// deserializes mode-0 MSB-first bytes together with the dc flag.
module spi_rx_byte #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n_i,
  input  logic       sck_i,
  input  logic       mosi_i,
  input  logic       dc_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       byte_dc_o
);

  // Bundle order {cs_n, sck, mosi, dc}; cs_n resets to the deselected level.
  localparam logic [3:0] SYNC_RST = 4'b1000;

  logic [3:0] link_s;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign link_s = {cs_n_i, sck_i, mosi_i, dc_i};
  end else begin : g_sync
    logic [3:0] sync_q [SYNC_STAGES];

    // Plain flop chain on every link input before any edge detection.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= SYNC_RST;
      end else begin
        sync_q[0] <= {cs_n_i, sck_i, mosi_i, dc_i};
        for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign link_s = sync_q[SYNC_STAGES-1];
  end

  logic cs_n_s, sck_s, mosi_s, dc_s;
  assign {cs_n_s, sck_s, mosi_s, dc_s} = link_s;

  logic       sck_prev_q;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] cnt_q, cnt_d;
  logic       byte_valid_q, byte_valid_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_dc_q, byte_dc_d;
  logic       sck_rise;

  assign sck_rise = sck_s & ~sck_prev_q;

  // Deserializer state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_prev_q   <= 1'b0;
      shreg_q      <= '0;
      cnt_q        <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_dc_q    <= 1'b0;
    end else begin
      sck_prev_q   <= sck_s;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_dc_q    <= byte_dc_d;
    end
  end

  // Shift on sck rise while selected; deselect drops any partial byte.
  always_comb begin
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_dc_d    = byte_dc_q;
    if (cs_n_s) begin
      cnt_d = 3'd0;
    end else if (sck_rise) begin
      shreg_d = {shreg_q[6:0], mosi_s};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        byte_valid_d = 1'b1;
        byte_data_d  = {shreg_q[6:0], mosi_s};
        byte_dc_d    = dc_s;
      end
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_data_o  = byte_data_q;
  assign byte_dc_o    = byte_dc_q;

endmodule

// File: rtl/ili9341_spi_rx.sv
// ILI9341 receive-side stand-in: decodes SWRESET/CASET/PASET/RAMWR from the
// serial link and emits RGB565 pixel writes with their x/y coordinates.
// Optional feature macro: ILI9341_RX_FRAME_DONE_EN (frame_done_o pulse on the
// last pixel of the window; tied to 0 when undefined).
module ili9341_spi_rx
  import ili9341_pkg::*;
#(
  parameter  int unsigned WIDTH       = 320,
  parameter  int unsigned HEIGHT      = 240,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned XW          = $clog2(WIDTH),
  localparam int unsigned YW          = $clog2(HEIGHT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ili9341_spi_rx_if.slave      link,
  output logic                 byte_valid_o,
  output logic [7:0]           byte_data_o,
  output logic                 byte_dc_o,
  output logic                 pixel_valid_o,
  output logic [15:0]          pixel_data_o,
  output logic [XW-1:0]        pixel_x_o,
  output logic [YW-1:0]        pixel_y_o,
  output logic                 win_err_o,
  output logic                 frame_done_o
);

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic       rb_valid;
  logic [7:0] rb_data;
  logic       rb_dc;

  spi_rx_byte #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_byte (
    .clk          (clk),
    .rst_n        (rst_n),
    .cs_n_i       (link.cs_n),
    .sck_i        (link.sck),
    .mosi_i       (link.mosi),
    .dc_i         (link.dc),
    .byte_valid_o (rb_valid),
    .byte_data_o  (rb_data),
    .byte_dc_o    (rb_dc)
  );

  rx_state_e     state_q, state_d;
  logic [XW-1:0] xs_q, xs_d, xe_q, xe_d, x_q, x_d;
  logic [YW-1:0] ys_q, ys_d, ye_q, ye_d, y_q, y_d;
  logic [15:0]   par_s_q, par_s_d;
  logic [7:0]    par_e_hi_q, par_e_hi_d;
  logic [7:0]    hi_q, hi_d;
  logic          win_err_q, win_err_d;
  logic          pixel_valid_q, pixel_valid_d;
  logic [15:0]   pixel_data_q, pixel_data_d;
  logic [XW-1:0] pixel_x_q, pixel_x_d;
  logic [YW-1:0] pixel_y_q, pixel_y_d;
`ifdef ILI9341_RX_FRAME_DONE_EN
  logic          frame_done_q, frame_done_d;
`endif

  // Decoder state, window, pointer and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      xs_q          <= '0;
      xe_q          <= X_LAST;
      ys_q          <= '0;
      ye_q          <= Y_LAST;
      x_q           <= '0;
      y_q           <= '0;
      par_s_q       <= '0;
      par_e_hi_q    <= '0;
      hi_q          <= '0;
      win_err_q     <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_data_q  <= '0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
`ifdef ILI9341_RX_FRAME_DONE_EN
      frame_done_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      xs_q          <= xs_d;
      xe_q          <= xe_d;
      ys_q          <= ys_d;
      ye_q          <= ye_d;
      x_q           <= x_d;
      y_q           <= y_d;
      par_s_q       <= par_s_d;
      par_e_hi_q    <= par_e_hi_d;
      hi_q          <= hi_d;
      win_err_q     <= win_err_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_data_q  <= pixel_data_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
`ifdef ILI9341_RX_FRAME_DONE_EN
      frame_done_q  <= frame_done_d;
`endif
    end
  end

  // Command decode, parameter collection and pixel/pointer sequencing.
  always_comb begin
    state_d       = state_q;
    xs_d          = xs_q;
    xe_d          = xe_q;
    ys_d          = ys_q;
    ye_d          = ye_q;
    x_d           = x_q;
    y_d           = y_q;
    par_s_d       = par_s_q;
    par_e_hi_d    = par_e_hi_q;
    hi_d          = hi_q;
    win_err_d     = win_err_q;
    pixel_valid_d = 1'b0;
    pixel_data_d  = pixel_data_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
`ifdef ILI9341_RX_FRAME_DONE_EN
    frame_done_d  = 1'b0;
`endif

    if (rb_valid) begin
      if (rb_dc) begin
        // A command always wins, whatever the sequence in progress.
        case (rb_data)
          CMD_CASET: state_d = ST_CASET0;
          CMD_PASET: state_d = ST_PASET0;
          CMD_RAMWR: begin
            if ((xs_q > xe_q) || (ys_q > ye_q)) begin
              win_err_d = 1'b1;
              state_d   = ST_SKIP;
            end else begin
              x_d     = xs_q;
              y_d     = ys_q;
              state_d = ST_RAMWR_HI;
            end
          end
          CMD_SWRESET: begin
            xs_d      = '0;
            xe_d      = X_LAST;
            ys_d      = '0;
            ye_d      = Y_LAST;
            win_err_d = 1'b0;
            state_d   = ST_IDLE;
          end
          default: state_d = ST_SKIP;
        endcase
      end else begin
        case (state_q)
          ST_CASET0: begin par_s_d[15:8] = rb_data; state_d = ST_CASET1; end
          ST_CASET1: begin par_s_d[7:0]  = rb_data; state_d = ST_CASET2; end
          ST_CASET2: begin par_e_hi_d    = rb_data; state_d = ST_CASET3; end
          ST_CASET3: begin
            xs_d    = XW'(par_s_q);
            xe_d    = XW'(clamp_end({par_e_hi_q, rb_data}, 16'(WIDTH - 1)));
            state_d = ST_IDLE;
          end
          ST_PASET0: begin par_s_d[15:8] = rb_data; state_d = ST_PASET1; end
          ST_PASET1: begin par_s_d[7:0]  = rb_data; state_d = ST_PASET2; end
          ST_PASET2: begin par_e_hi_d    = rb_data; state_d = ST_PASET3; end
          ST_PASET3: begin
            ys_d    = YW'(par_s_q);
            ye_d    = YW'(clamp_end({par_e_hi_q, rb_data}, 16'(HEIGHT - 1)));
            state_d = ST_IDLE;
          end
          ST_RAMWR_HI: begin
            hi_d    = rb_data;
            state_d = ST_RAMWR_LO;
          end
          ST_RAMWR_LO: begin
            pixel_valid_d = 1'b1;
            pixel_data_d  = {hi_q, rb_data};
            pixel_x_d     = x_q;
            pixel_y_d     = y_q;
`ifdef ILI9341_RX_FRAME_DONE_EN
            frame_done_d  = (x_q == xe_q) && (y_q == ye_q);
`endif
            if (x_q == xe_q) begin
              x_d = xs_q;
              y_d = (y_q == ye_q) ? ys_q : y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
            state_d = ST_RAMWR_HI;
          end
          default: ;
        endcase
      end
    end
  end

  assign byte_valid_o  = rb_valid;
  assign byte_data_o   = rb_data;
  assign byte_dc_o     = rb_dc;
  assign pixel_valid_o = pixel_valid_q;
  assign pixel_data_o  = pixel_data_q;
  assign pixel_x_o     = pixel_x_q;
  assign pixel_y_o     = pixel_y_q;
  assign win_err_o     = win_err_q;
`ifdef ILI9341_RX_FRAME_DONE_EN
  assign frame_done_o  = frame_done_q;
`else
  assign frame_done_o  = 1'b0;
`endif

endmodule

// File: tb/tb_ili9341_spi_rx.sv
// Bench for ili9341_spi_rx: directed scenarios then random traffic, compared
// against a command-level model of the display's window/pointer rules.
module tb_ili9341_spi_rx;
  import ili9341_pkg::*;

  localparam int unsigned W  = 320;
  localparam int unsigned H  = 240;
  localparam int unsigned XW = $clog2(W);
  localparam int unsigned YW = $clog2(H);
`ifdef ILI9341_RX_FRAME_DONE_EN
  localparam bit FD_EN = 1'b1;
`else
  localparam bit FD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ili9341_spi_rx_if link ();

  logic          byte_valid, byte_dc, pixel_valid, win_err, frame_done;
  logic [7:0]    byte_data;
  logic [15:0]   pixel_data;
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] pixel_y;

  ili9341_spi_rx #(.WIDTH(W), .HEIGHT(H), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .link          (link),
    .byte_valid_o  (byte_valid),
    .byte_data_o   (byte_data),
    .byte_dc_o     (byte_dc),
    .pixel_valid_o (pixel_valid),
    .pixel_data_o  (pixel_data),
    .pixel_x_o     (pixel_x),
    .pixel_y_o     (pixel_y),
    .win_err_o     (win_err),
    .frame_done_o  (frame_done)
  );

  // ---------------- output monitor ----------------
  typedef struct packed {
    logic          pv;
    logic          fd;
    logic          prev_bv;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [15:0]   d;
  } pev_t;

  logic [8:0] mb [4096];
  pev_t       mp [4096];
  int         mb_wr = 0;
  int         mp_wr = 0;
  logic       prev_bv = 1'b0;

  // Record every byte and every pixel/frame_done event, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid) begin
        mb[mb_wr[11:0]] <= {byte_dc, byte_data};
        mb_wr <= mb_wr + 1;
      end
      if (pixel_valid || frame_done) begin
        mp[mp_wr[11:0]] <= '{pv: pixel_valid, fd: frame_done, prev_bv: prev_bv,
                             x: pixel_x, y: pixel_y, d: pixel_data};
        mp_wr <= mp_wr + 1;
      end
    end
    prev_bv <= byte_valid;
  end

  // ---------------- reference model ----------------
  typedef struct {int x; int y; int d; bit fd;} epix_t;

  logic [8:0] exp_b [$];
  epix_t      exp_p [$];
  int m_xs, m_xe, m_ys, m_ye, m_px, m_py, m_cmd, m_np, m_hi;
  int m_prm [4];
  bit m_werr, m_have_hi;

  int errors = 0;
  int checks = 0;
  int b_rd = 0;
  int p_rd = 0;

  task automatic m_reset();
    m_xs = 0; m_xe = W - 1; m_ys = 0; m_ye = H - 1;
    m_px = 0; m_py = 0; m_cmd = 0; m_np = 0; m_hi = 0;
    m_werr = 1'b0; m_have_hi = 1'b0;
  endtask

  // One received byte as the display sees it.
  task automatic m_byte(input bit is_cmd, input int v);
    int s, e, lim, mask;
    exp_b.push_back({is_cmd, 8'(v)});
    if (is_cmd) begin
      m_np = 0; m_have_hi = 1'b0; m_cmd = 0;
      if (v == 'h2A || v == 'h2B) m_cmd = v;
      else if (v == 'h2C) begin
        if (m_xs > m_xe || m_ys > m_ye) m_werr = 1'b1;
        else begin m_cmd = v; m_px = m_xs; m_py = m_ys; end
      end else if (v == 'h01) begin
        m_xs = 0; m_xe = W - 1; m_ys = 0; m_ye = H - 1; m_werr = 1'b0;
      end
    end else if (m_cmd == 'h2A || m_cmd == 'h2B) begin
      m_prm[m_np] = v;
      m_np++;
      if (m_np == 4) begin
        lim  = (m_cmd == 'h2A) ? W - 1 : H - 1;
        mask = (m_cmd == 'h2A) ? (1 << XW) - 1 : (1 << YW) - 1;
        s = (m_prm[0] * 256 + m_prm[1]) & mask;
        e = m_prm[2] * 256 + m_prm[3];
        if (e > lim) e = lim;
        if (m_cmd == 'h2A) begin m_xs = s; m_xe = e; end
        else               begin m_ys = s; m_ye = e; end
        m_cmd = 0;
      end
    end else if (m_cmd == 'h2C) begin
      if (!m_have_hi) begin
        m_hi = v; m_have_hi = 1'b1;
      end else begin
        exp_p.push_back('{m_px, m_py, m_hi * 256 + v, FD_EN && m_px == m_xe && m_py == m_ye});
        m_have_hi = 1'b0;
        if (m_px == m_xe) begin
          m_px = m_xs;
          m_py = (m_py == m_ye) ? m_ys : m_py + 1;
        end else m_px++;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "/byte_valid"},  32'(byte_valid), 0);
    chk({tag, "/byte_data"},   32'(byte_data), 0);
    chk({tag, "/byte_dc"},     32'(byte_dc), 0);
    chk({tag, "/pixel_valid"}, 32'(pixel_valid), 0);
    chk({tag, "/pixel_data"},  32'(pixel_data), 0);
    chk({tag, "/pixel_x"},     32'(pixel_x), 0);
    chk({tag, "/pixel_y"},     32'(pixel_y), 0);
    chk({tag, "/win_err"},     32'(win_err), 0);
    chk({tag, "/frame_done"},  32'(frame_done), 0);
  endtask

  // Let the pipeline drain, then compare everything observed against the model.
  task automatic flush(input string tag);
    epix_t ep;
    pev_t  op;
    repeat (10) @(negedge clk);
    chk({tag, "/nbytes"}, 32'(mb_wr - b_rd), 32'(exp_b.size()));
    while (b_rd < mb_wr && exp_b.size() > 0) begin
      chk({tag, "/byte"}, 32'(mb[b_rd[11:0]]), 32'(exp_b.pop_front()));
      b_rd++;
    end
    chk({tag, "/npix"}, 32'(mp_wr - p_rd), 32'(exp_p.size()));
    while (p_rd < mp_wr && exp_p.size() > 0) begin
      ep = exp_p.pop_front();
      op = mp[p_rd[11:0]];
      chk({tag, "/pix_valid"}, 32'(op.pv), 1);
      chk({tag, "/pix_after_byte"}, 32'(op.prev_bv), 1);
      chk({tag, "/pix_x"}, 32'(op.x), 32'(ep.x));
      chk({tag, "/pix_y"}, 32'(op.y), 32'(ep.y));
      chk({tag, "/pix_data"}, 32'(op.d), 32'(ep.d));
      chk({tag, "/frame_done"}, 32'(op.fd), 32'(ep.fd));
      p_rd++;
    end
    chk({tag, "/win_err"}, 32'(win_err), 32'(m_werr));
    b_rd = mb_wr; p_rd = mp_wr;
    exp_b.delete(); exp_p.delete();
  endtask

  // ---------------- link driver ----------------
  task automatic send_bits(input logic [7:0] b, input bit d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      link.sck = 1'b0; link.mosi = b[7-i]; link.dc = d;
      @(negedge clk);
      link.sck = 1'b1;
    end
    @(negedge clk);
    link.sck = 1'b0;
  endtask

  task automatic send(input int v, input bit d);
    send_bits(8'(v), d, 8);
    m_byte(d, v);
  endtask

  task automatic set_cs(input bit v);
    @(negedge clk);
    link.cs_n = v;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_win(input int cmd, input int s, input int e);
    send(cmd, 1);
    send(s >> 8, 0); send(s & 255, 0);
    send(e >> 8, 0); send(e & 255, 0);
  endtask

  task automatic send_pix(input int n);
    for (int i = 0; i < n; i++) begin
      send(int'($urandom_range(0, 255)), 0);
      send(int'($urandom_range(0, 255)), 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int op, s, e, n;
    link.cs_n = 1'b1; link.sck = 1'b0; link.mosi = 1'b0; link.dc = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // Single data byte: one byte event, no pixel.
    set_cs(0);
    send('hA5, 0);
    set_cs(1);
    flush("single");

    // Window 2..3 x 5..6, five red pixels; the fifth wraps to (2,5).
    set_cs(0);
    send_win('h2A, 2, 3);
    send_win('h2B, 5, 6);
    send('h2C, 1);
    for (int i = 0; i < 5; i++) begin
      send(int'(COLOR_RED[15:8]), 0);
      send(int'(COLOR_RED[7:0]), 0);
    end
    flush("window");

    // Partial byte discarded by deselect.
    send_bits(8'hFF, 0, 5);
    set_cs(1);
    set_cs(0);
    send('h3C, 0);
    flush("abort");

    // Odd high byte dropped by a command; following data ignored.
    send('h2C, 1); send('hF8, 0); send('h00, 1);
    send('h11, 0); send('h22, 0); send('h33, 0); send('h44, 0);
    flush("odd_drop");

    // Inverted window: error, no pixels; SWRESET clears it and restores x range.
    send_win('h2A, 9, 4);
    send('h2C, 1); send('hF8, 0); send('h00, 0);
    flush("bad_win");
    send('h01, 1);
    send('h2C, 1);
    send_pix(2);
    flush("swreset");

    // Bottom-right corner with end clamped, plus start truncation.
    send_win('h2A, 318, 400);
    send_win('h2B, 239, 239);
    send('h2C, 1);
    send_pix(3);
    flush("corner");
    send_win('h2A, 513, 517);
    send('h2C, 1);
    send_pix(2);
    flush("trunc");

    // Synchronous reset during the low byte of a pixel.
    send('h2C, 1); send('h12, 0);
    flush("pre_reset");
    send_bits(8'h34, 0, 4);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midreset");
    rst_n = 1'b1;
    set_cs(1);
    m_reset();
    b_rd = mb_wr; p_rd = mp_wr;
    exp_b.delete(); exp_p.delete();
    set_cs(0);
    send('h2C, 1);
    send_pix(1);
    flush("post_reset");

    // Random command/data traffic.
    for (int it = 0; it < 60; it++) begin
      op = int'($urandom_range(0, 6));
      case (op)
        0, 1: begin
          s = int'($urandom_range(0, 600));
          e = int'($urandom_range(0, (op == 0) ? W + 40 : H + 40));
          n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 4;
          send((op == 0) ? 'h2A : 'h2B, 1);
          if (n > 0) send(s >> 8, 0);
          if (n > 1) send(s & 255, 0);
          if (n > 2) send(e >> 8, 0);
          if (n > 3) send(e & 255, 0);
        end
        2: begin
          send('h2C, 1);
          n = int'($urandom_range(0, 7));
          for (int i = 0; i < n; i++) send(int'($urandom_range(0, 255)), 0);
        end
        3: begin
          send(int'($urandom_range(0, 255)), 1);
          send(int'($urandom_range(0, 255)), 0);
        end
        4: begin
          send_bits(8'($urandom_range(0, 255)), 0, int'($urandom_range(1, 7)));
          set_cs(1);
          set_cs(0);
        end
        5: begin
          if ($urandom_range(0, 3) == 0) send('h01, 1);
          else send(int'($urandom_range(0, 255)), 0);
        end
        default: begin
          s = int'($urandom_range(0, W - 2));
          send_win('h2A, s, s + int'($urandom_range(0, 1)));
          s = int'($urandom_range(0, H - 2));
          send_win('h2B, s, s + int'($urandom_range(0, 1)));
          send('h2C, 1);
          send_pix(int'($urandom_range(1, 6)));
        end
      endcase
      flush("rnd");
    end

    set_cs(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
